// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-lane register file with a per-entry pending-write
// counter. Reads return data and a busy flag one cycle after the request, so
// issue logic can detect RAW hazards directly from the register file.
// Optional feature: define REGFILE_BYPASS_EN so that reads see the same-cycle
// winning write data and the post-update pending count.
module regfile_scoreboard #(
  parameter int LANES    = 4,
  parameter int RPORTS   = 2,
  parameter int ENTRIES  = 32,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = $clog2(ENTRIES),
  parameter int CNT_W    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [LANES*RPORTS-1:0]           rd_valid,
  input  logic [LANES*RPORTS*ADDR_W-1:0]    rd_addr,
  output logic [LANES*RPORTS*DATA_W-1:0]    rd_data,
  output logic [LANES*RPORTS-1:0]           rd_busy,
  input  logic [LANES-1:0]                  rsv_valid,
  input  logic [LANES*ADDR_W-1:0]           rsv_addr,
  output logic                              rsv_stall,
  input  logic [LANES-1:0]                  wr_valid,
  input  logic [LANES*ADDR_W-1:0]           wr_addr,
  input  logic [LANES*DATA_W-1:0]           wr_data,
  output logic                              underflow
);

  localparam int NRP   = LANES * RPORTS;
  // Wide enough to hold a full counter plus one reservation per lane.
  localparam int SUM_W = CNT_W + $clog2(LANES + 1) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [DATA_W-1:0] r_mem [ENTRIES];
  logic [CNT_W-1:0]  r_cnt [ENTRIES];
  logic              r_underflow;
  logic [NRP*DATA_W-1:0] r_rd_data;
  logic [NRP-1:0]        r_rd_busy;

  logic [SUM_W-1:0]  w_nrsv    [ENTRIES];
  logic [SUM_W-1:0]  w_nwr     [ENTRIES];
  logic [SUM_W-1:0]  w_after   [ENTRIES];
  logic [CNT_W-1:0]  w_cnt_nxt [ENTRIES];
  logic              w_wr_hit  [ENTRIES];
  logic [DATA_W-1:0] w_wr_dat  [ENTRIES];
  logic [ENTRIES-1:0] w_uf_e;
  logic              w_stall;
  logic [ADDR_W-1:0] w_rd_a    [NRP];
  logic [NRP*DATA_W-1:0] w_rd_data;
  logic [NRP-1:0]        w_rd_busy;

  // Per entry: count reservations and writes, and pick the highest-lane write data.
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      w_nrsv[e]   = '0;
      w_nwr[e]    = '0;
      w_wr_hit[e] = 1'b0;
      w_wr_dat[e] = '0;
      if (ZERO_REG == 0 || e != 0) begin
        for (int l = 0; l < LANES; l++) begin
          if (rsv_valid[l] && rsv_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(e))
            w_nrsv[e] = w_nrsv[e] + SUM_W'(1);
          if (wr_valid[l] && wr_addr[l*ADDR_W +: ADDR_W] == ADDR_W'(e)) begin
            w_nwr[e]    = w_nwr[e] + SUM_W'(1);
            w_wr_hit[e] = 1'b1;
            w_wr_dat[e] = wr_data[l*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // All-or-nothing reservation check; same-cycle writes are deliberately not credited.
  always_comb begin
    w_stall = 1'b0;
    for (int e = 0; e < ENTRIES; e++) begin
      if ({{(SUM_W-CNT_W){1'b0}}, r_cnt[e]} + w_nrsv[e] > CNT_MAX)
        w_stall = 1'b1;
    end
  end

  // Next pending count: add accepted reservations, then retire writes saturating at 0.
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      w_after[e]   = {{(SUM_W-CNT_W){1'b0}}, r_cnt[e]} + (w_stall ? '0 : w_nrsv[e]);
      w_uf_e[e]    = (w_nwr[e] > w_after[e]);
      w_cnt_nxt[e] = w_uf_e[e] ? '0 : CNT_W'(w_after[e] - w_nwr[e]);
    end
  end

  // Storage, pending counters and the sticky underflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < ENTRIES; e++) begin
        r_mem[e] <= '0;
        r_cnt[e] <= '0;
      end
      r_underflow <= 1'b0;
    end else begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_wr_hit[e])
          r_mem[e] <= w_wr_dat[e];
        r_cnt[e] <= w_cnt_nxt[e];
      end
      if (|w_uf_e)
        r_underflow <= 1'b1;
    end
  end

  // Read port lookup; the zero register and idle ports return zeros.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int p = 0; p < NRP; p++) begin
      w_rd_a[p] = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_valid[p] && !(ZERO_REG != 0 && w_rd_a[p] == '0)) begin
`ifdef REGFILE_BYPASS_EN
        w_rd_data[p*DATA_W +: DATA_W] = w_wr_hit[w_rd_a[p]] ? w_wr_dat[w_rd_a[p]]
                                                            : r_mem[w_rd_a[p]];
        w_rd_busy[p] = (w_cnt_nxt[w_rd_a[p]] != '0);
`else
        w_rd_data[p*DATA_W +: DATA_W] = r_mem[w_rd_a[p]];
        w_rd_busy[p] = (r_cnt[w_rd_a[p]] != '0);
`endif
      end
    end
  end

  // One-cycle registered read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      r_rd_data <= w_rd_data;
      r_rd_busy <= w_rd_busy;
    end
  end

  assign rd_data   = r_rd_data;
  assign rd_busy   = r_rd_busy;
  assign rsv_stall = w_stall;
  assign underflow = r_underflow;

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-lane register file with an integrated per-entry pending-write scoreboard for the parallel pipeline. Up to LANES instructions per cycle read operands, reserve destinations and retire writes. Reads return data and a busy flag one cycle later, so issue logic can detect RAW hazards without a separate scoreboard block.

## Interface
- LANES, 4, parallel issue lanes (≥1)
- RPORTS, 2, read ports per lane (≥1)
- ENTRIES, 32, architectural registers (power of two, ≥2)
- DATA_W, 32, register data width
- ADDR_W, $clog2(ENTRIES), register address width
- CNT_W, 2, pending-write counter width per entry; max outstanding = 2^CNT_W−1
- ZERO_REG, 1, 1: entry 0 reads as 0, ignores writes and reservations, never busy

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rd_valid  in  LANES*RPORTS  read request per port (port p of lane l at index l*RPORTS+p)
- rd_addr  in  LANES*RPORTS*ADDR_W  read addresses
- rd_data  out  LANES*RPORTS*DATA_W  registered read data; 0 when rd_valid was low
- rd_busy  out  LANES*RPORTS  registered: addressed entry had pending count ≠0; 0 when rd_valid was low
- rsv_valid  in  LANES  reserve destination (increment pending count)
- rsv_addr  in  LANES*ADDR_W  reserve addresses
- rsv_stall  out  1  combinational: this cycle's reservations rejected
- wr_valid  in  LANES  write-back request
- wr_addr  in  LANES*ADDR_W  write addresses
- wr_data  in  LANES*DATA_W  write data
- underflow  out  1  sticky: a write hit an entry with pending count 0

## Operation
- Storage: ENTRIES×DATA_W array plus ENTRIES×CNT_W pending counters.
- Writes: all valid lanes applied same cycle; same-address conflict → highest lane index wins data. Each valid write decrements its entry's count by 1 (per lane, so two lanes writing same entry decrement by 2), saturating at 0; a decrement attempted at 0 sets underflow.
- Reservations: all-or-nothing. rsv_stall = 1 if, for any entry, current count + number of valid reservations targeting it > 2^CNT_W−1. Same-cycle writes are not credited (conservative). If rsv_stall=1, no count is incremented; writes still apply.
- Net count update per entry = count + accepted reservations − writes (with underflow rule per write at 0 checked against count after adding reservations).
- ZERO_REG=1: address 0 excluded from write, reserve, stall and underflow logic; reads of 0 give data 0, busy 0.
- Reads: port independent; rd_data/rd_busy captured at posedge.

## Timing
- Read latency 1 cycle: request at edge N−1..N → rd_data/rd_busy valid after edge N.
- Write and count update visible in storage after the edge they are sampled on.
- rsv_stall combinational from rsv_valid, rsv_addr and current counts; no dependency on wr_* (no loop).
- Reset (async assert, sync-to-clk deassert by upstream): all storage 0, all counts 0, rd_data 0, rd_busy 0, underflow 0; rsv_stall reflects inputs with counts 0.
- Reset mid-operation: pending counts lost; issue logic must flush.

## Configuration
- REGFILE_BYPASS_EN defined: read on same cycle as a write to the same address returns the winning write data; rd_busy reflects the post-update count (including accepted reservations and writes of that cycle).
- Not defined: reads return pre-write array contents and pre-update count; one extra cycle before written data is readable.

## Test plan
- Reset, then read all entries on every port → rd_data 0, rd_busy 0, underflow 0, rsv_stall 0.
- Lanes 0 and 3 write addr 5 with 0xAAAA/0xBBBB same cycle; read addr 5 next cycle → 0xBBBB.
- Reserve addr 7 three times (CNT_W=2) → count 3, rd_busy 1; fourth reserve → rsv_stall 1, count stays 3; three writes → rd_busy 0.
- Lanes 0,1 reserve addr 9 and lane 2 reserves addr 10 while addr 9 count=2 → rsv_stall 1, addr 10 not incremented.
- Write addr 4 at count 0 → underflow 1 and stays 1 until reset; write addr 0 data 0x1234 → read 0 returns 0.
- Same-cycle write 0x55 and read of addr 3: with REGFILE_BYPASS_EN → 0x55; without → old value, 0x55 on the following read.
